// File: rtl/ram_param.sv
// ---------------------------------------------------------------------------
// ram_param : parametrised single-port RAM with a hardware clear sweep.
//
// After reset, or when `clear` is asserted while idle, the RAM walks every
// word from address 0 to DEPTH-1 and writes CLEAR_VAL into it, one word per
// clock. `busy` is high for the whole sweep so a sequencer can stall; writes
// and clear requests arriving during the sweep are dropped.
//
// Parameters:
//   WIDTH     data word width in bits
//   ADDR_W    address width in bits, DEPTH = 2**ADDR_W
//   CLEAR_VAL value written to every word by the clear sweep
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst_n    asynchronous reset, active low
//   in       write data
//   load     write enable (honoured only when idle)
//   address  read/write address
//   clear    request to re-run the clear sweep (honoured only when idle)
//   out      read data, forced to 0 while the sweep runs
//   busy     high while the clear sweep is in progress
//
// Build option:
//   RAM_PARAM_READ_REG_EN  when defined, `out` is a registered, write-first
//                          read port (one cycle of latency). When undefined,
//                          `out` is a combinational read of mem[address].
// ---------------------------------------------------------------------------
module ram_param #(
    parameter int               WIDTH     = 16,
    parameter int               ADDR_W    = 6,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    // The last word of the sweep is the all-ones address.
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              sweeping;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    assign sweeping = (state == S_CLEAR);
    assign busy     = sweeping;

    // Sweep sequencer. Reset lands in CLEAR with the pointer at word 0, so
    // the sweep takes exactly DEPTH edges once rst_n is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            ptr   <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (ptr == LAST_ADDR) begin
                        state <= S_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                S_IDLE: begin
                    if (clear) begin
                        state <= S_CLEAR;
                        ptr   <= '0;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Single write port shared by the sweep and the user. In IDLE a clear
    // request takes priority, so a simultaneous load is discarded.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = address;
        wr_data = in;
        if (sweeping) begin
            wr_en   = 1'b1;
            wr_addr = ptr;
            wr_data = CLEAR_VAL;
        end else if (load && !clear) begin
            wr_en = 1'b1;
        end
    end

    // Storage carries no reset; its defined contents come from the sweep.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef RAM_PARAM_READ_REG_EN
    logic [WIDTH-1:0] out_q;

    // Registered write-first read. The register only loads while staying in
    // IDLE, so it reads 0 throughout the sweep and on the first IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (!sweeping && !clear) begin
            out_q <= load ? in : mem[address];
        end else begin
            out_q <= '0;
        end
    end

    assign out = out_q;
`else
    // Combinational read; a write at edge n is visible from cycle n+1.
    assign out = sweeping ? '0 : mem[address];
`endif

endmodule

// File: tb/tb_ram_param.sv
// ---------------------------------------------------------------------------
// tb_ram_param : scoreboard testbench for ram_param (WIDTH=16, ADDR_W=6).
//
// The stimulus process drives inputs on falling edges and pushes expected
// (out, busy) values into a queue sorted by the falling-edge index at which
// they must hold. A monitor samples the DUT 1 time unit after every falling
// edge and pops and compares the entries due at that index.
// ---------------------------------------------------------------------------
module tb_ram_param;

`ifdef RAM_PARAM_READ_REG_EN
    localparam logic [15:0] CV     = 16'h00FF;
    localparam int          RD_LAT = 1;
`else
    localparam logic [15:0] CV     = 16'h0000;
    localparam int          RD_LAT = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic [5:0]  address;
    logic        clear;
    logic [15:0] out;
    logic        busy;

    ram_param #(
        .WIDTH    (16),
        .ADDR_W   (6),
        .CLEAR_VAL(CV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .load   (load),
        .address(address),
        .clear  (clear),
        .out    (out),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int          due;
        logic [15:0] exp_out;
        logic        exp_busy;
        logic        chk_out;
    } sb_entry_t;

    sb_entry_t sb[$];
    string     sb_name[$];

    int ncount = 0;
    int checks = 0;
    int passes = 0;

    // Insert keeping the queue ordered by due index.
    task automatic expectAt(input int due, input string name, input logic [15:0] eo,
                            input logic eb, input logic co);
        sb_entry_t e;
        int        pos;
        e.due      = due;
        e.exp_out  = eo;
        e.exp_busy = eb;
        e.chk_out  = co;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].due > due) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
        sb_name.insert(pos, name);
    endtask

    task automatic checkOutput(input sb_entry_t e, input string name);
        checks++;
        if (e.due < ncount) begin
            $display("[TB] FAIL %s: check missed, due at edge %0d, now %0d", name, e.due, ncount);
        end else if ((busy !== e.exp_busy) || (e.chk_out && (out !== e.exp_out))) begin
            $display("[TB] FAIL %s: got out=%h busy=%b, expected out=%h busy=%b%s",
                     name, out, busy, e.exp_out, e.exp_busy, e.chk_out ? "" : " (out not checked)");
        end else begin
            passes++;
        end
    endtask

    // Monitor: sample after the falling edge once inputs have settled.
    always @(negedge clk) begin
        #1;
        ncount++;
        while (sb.size() > 0 && sb[0].due <= ncount) begin
            checkOutput(sb.pop_front(), sb_name.pop_front());
        end
    end

    task automatic applyStimulus(input logic ld, input logic clr, input logic [5:0] a,
                                 input logic [15:0] d, output int idx);
        @(negedge clk);
        load    = ld;
        clear   = clr;
        address = a;
        in      = d;
        idx     = ncount + 1;
    endtask

    task automatic applyReset(input logic v, output int idx);
        @(negedge clk);
        rst_n   = v;
        load    = 1'b0;
        clear   = 1'b0;
        address = '0;
        in      = '0;
        idx     = ncount + 1;
    endtask

    task automatic idleCycles(input int n);
        int idx;
        repeat (n) applyStimulus(1'b0, 1'b0, 6'd0, 16'h0000, idx);
    endtask

    task automatic readCheck(input logic [5:0] a, input logic [15:0] exp, input string name);
        int idx;
        applyStimulus(1'b0, 1'b0, a, 16'h0000, idx);
        expectAt(idx + RD_LAT, name, exp, 1'b0, 1'b1);
    endtask

    task automatic writeWord(input logic [5:0] a, input logic [15:0] d);
        int idx;
        applyStimulus(1'b1, 1'b0, a, d, idx);
    endtask

    int r, s, q, n, m, idx;

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        address = '0;
        in      = '0;

        // Power-up reset, then a full sweep of exactly 64 cycles.
        expectAt(1, "reset_state", 16'h0000, 1'b1, 1'b1);
        applyReset(1'b1, r);
        expectAt(r + 63, "sweep_last", 16'h0000, 1'b1, 1'b1);
        expectAt(r + 64, "sweep_done", 16'h0000, 1'b0, 1'b0);
        idleCycles(63);
        readCheck(6'd0,  CV, "rd0_after_sweep");
        readCheck(6'd31, CV, "rd31_after_sweep");
        readCheck(6'd63, CV, "rd63_after_sweep");

        // Plain writes and reads.
        writeWord(6'd5,  16'hBEEF);
        writeWord(6'd63, 16'h1234);
        readCheck(6'd5,  16'hBEEF, "rd5_beef");
        readCheck(6'd63, 16'h1234, "rd63_1234");
        readCheck(6'd6,  CV,       "rd6_untouched");

        // Clear and load together: clear wins. During the sweep, loads and a
        // second clear request are ignored.
        applyStimulus(1'b1, 1'b1, 6'd7, 16'hAAAA, s);
        expectAt(s + 1,  "clear_busy",      16'h0000, 1'b1, 1'b1);
        expectAt(s + 64, "clear_busy_last", 16'h0000, 1'b1, 1'b1);
        expectAt(s + 65, "clear_done",      16'h0000, 1'b0, 1'b0);
        for (int k = 1; k <= 64; k++) begin
            if (k == 10)      applyStimulus(1'b1, 1'b0, 6'd60, 16'h5555, idx);
            else if (k == 30) applyStimulus(1'b1, 1'b0, 6'd2,  16'h5555, idx);
            else if (k == 40) applyStimulus(1'b0, 1'b1, 6'd0,  16'h0000, idx);
            else              applyStimulus(1'b0, 1'b0, 6'd0,  16'h0000, idx);
        end
        readCheck(6'd7,  CV, "rd7_clear_wins");
        readCheck(6'd5,  CV, "rd5_cleared");
        readCheck(6'd60, CV, "rd60_load_dropped");
        readCheck(6'd2,  CV, "rd2_load_dropped");

        // Reset in the middle of a sweep restarts it from word 0.
        applyStimulus(1'b0, 1'b1, 6'd0, 16'h0000, s);
        idleCycles(29);
        applyReset(1'b0, q);
        expectAt(q, "rst_mid_sweep", 16'h0000, 1'b1, 1'b1);
        idleCycles(1);
        applyReset(1'b1, r);
        expectAt(r + 63, "resweep_last", 16'h0000, 1'b1, 1'b1);
        expectAt(r + 64, "resweep_done", 16'h0000, 1'b0, 1'b0);
        idleCycles(63);
        readCheck(6'd63, CV, "rd63_after_resweep");

        // Write then move the address away on the following edge.
        applyStimulus(1'b1, 1'b0, 6'd3, 16'h0F0F, n);
`ifdef RAM_PARAM_READ_REG_EN
        expectAt(n + 1, "write_first", 16'h0F0F, 1'b0, 1'b1);
`else
        expectAt(n, "pre_write_old", CV, 1'b0, 1'b1);
`endif
        applyStimulus(1'b0, 1'b0, 6'd4, 16'h0000, m);
        expectAt(m + RD_LAT, "rd4_clearval", CV, 1'b0, 1'b1);
        readCheck(6'd3, 16'h0F0F, "rd3_0f0f");

        // Reset while idle and presenting data forces out/busy at once.
        writeWord(6'd10, 16'h1234);
        applyStimulus(1'b0, 1'b0, 6'd10, 16'h0000, idx);
        applyStimulus(1'b0, 1'b0, 6'd10, 16'h0000, idx);
        expectAt(idx, "rd10_before_rst", 16'h1234, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        q = ncount + 1;
        expectAt(q, "rst_in_idle", 16'h0000, 1'b1, 1'b1);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
        #2;
        if (sb.size() > 0) begin
            $display("[TB] FAIL drain: %0d expectations never checked, expected 0", sb.size());
            checks += sb.size();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
